// File: rtl/morse_decoder.sv
// Serial Morse decoder for the S..Z letter set: classifies mark/space runs
// sampled on sym_tick into dots and dashes and reports a 3-bit letter code.
module morse_decoder #(
    parameter int MAX_ELEMS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sym_tick,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       busy,
    output logic [2:0] elem_count
);

    localparam int         ELEM_W   = (MAX_ELEMS > 4) ? MAX_ELEMS : 4;
    localparam logic [2:0] ELEM_MAX = 3'(MAX_ELEMS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARK    = 2'd1,
        SPACE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_mark_cnt;
    logic [1:0]        r_space_cnt;
    logic [1:0]        r_zero_cnt;
    logic [ELEM_W-1:0] r_elems;
    logic [2:0]        r_elem_count;
    logic [2:0]        r_letter;
    logic              r_letter_valid;
    logic              r_error;
    logic              r_busy;
    logic              w_match;
    logic [2:0]        w_code;

    // Element bit i is the i-th element received, 1 = dash. Result is {match, code}.
    function automatic logic [3:0] decode_elems(input logic [2:0] count, input logic [3:0] elems);
        logic [3:0] res;
        res = 4'b0000;
        case (count)
            3'd1: begin
                if (elems[0]) begin
                    res = 4'b1001;
                end else begin
                    res = 4'b0000;
                end
            end
            3'd3: begin
                case (elems[2:0])
                    3'b000:  res = 4'b1000;
                    3'b100:  res = 4'b1010;
                    3'b110:  res = 4'b1100;
                    default: res = 4'b0000;
                endcase
            end
            3'd4: begin
                case (elems)
                    4'b1000: res = 4'b1011;
                    4'b1001: res = 4'b1101;
                    4'b1101: res = 4'b1110;
                    4'b0011: res = 4'b1111;
                    default: res = 4'b0000;
                endcase
            end
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Combinational lookup of the element store, consumed at end of character.
    always_comb begin
        w_match = 1'b0;
        w_code  = 3'b000;
        {w_match, w_code} = decode_elems(r_elem_count, r_elems[3:0]);
    end

    // Receiver FSM; state and pulses only move on sym_tick, pulses self-clear each clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_mark_cnt     <= 3'd0;
            r_space_cnt    <= 2'd0;
            r_zero_cnt     <= 2'd0;
            r_elems        <= '0;
            r_elem_count   <= 3'd0;
            r_letter       <= 3'b000;
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
            if (sym_tick) begin
                case (r_state)
                    IDLE: begin
                        if (morse_in) begin
                            r_state    <= MARK;
                            r_mark_cnt <= 3'd1;
                            r_busy     <= 1'b1;
                        end
                    end
                    MARK: begin
                        if (morse_in) begin
                            if (r_mark_cnt == 3'd3) begin
                                r_error      <= 1'b1;
                                r_state      <= RECOVER;
                                r_zero_cnt   <= 2'd0;
                                r_mark_cnt   <= 3'd0;
                                r_space_cnt  <= 2'd0;
                                r_elems      <= '0;
                                r_elem_count <= 3'd0;
                            end else begin
                                r_mark_cnt <= r_mark_cnt + 3'd1;
                            end
                        end else if ((r_mark_cnt == 3'd2) || (r_elem_count == ELEM_MAX)) begin
                            // The deciding zero already counts toward recovery.
                            r_error      <= 1'b1;
                            r_state      <= RECOVER;
                            r_zero_cnt   <= 2'd1;
                            r_mark_cnt   <= 3'd0;
                            r_space_cnt  <= 2'd0;
                            r_elems      <= '0;
                            r_elem_count <= 3'd0;
                        end else begin
                            for (int i = 0; i < ELEM_W; i++) begin
                                if (r_elem_count == 3'(i)) begin
                                    r_elems[i] <= (r_mark_cnt == 3'd3);
                                end
                            end
                            r_elem_count <= r_elem_count + 3'd1;
                            r_mark_cnt   <= 3'd0;
                            r_space_cnt  <= 2'd1;
                            r_state      <= SPACE;
                        end
                    end
                    SPACE: begin
                        if (morse_in) begin
                            if (r_space_cnt == 2'd1) begin
                                r_state     <= MARK;
                                r_mark_cnt  <= 3'd1;
                                r_space_cnt <= 2'd0;
                            end else begin
                                r_error      <= 1'b1;
                                r_state      <= RECOVER;
                                r_zero_cnt   <= 2'd0;
                                r_mark_cnt   <= 3'd0;
                                r_space_cnt  <= 2'd0;
                                r_elems      <= '0;
                                r_elem_count <= 3'd0;
                            end
                        end else if (r_space_cnt == 2'd2) begin
                            if (w_match) begin
                                r_letter       <= w_code;
                                r_letter_valid <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_space_cnt  <= 2'd0;
                            r_elems      <= '0;
                            r_elem_count <= 3'd0;
                        end else begin
                            r_space_cnt <= r_space_cnt + 2'd1;
                        end
                    end
                    RECOVER: begin
                        if (morse_in) begin
                            r_zero_cnt <= 2'd0;
                        end else if (r_zero_cnt == 2'd2) begin
                            r_zero_cnt <= 2'd0;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_zero_cnt <= r_zero_cnt + 2'd1;
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_mark_cnt   <= 3'd0;
                        r_space_cnt  <= 2'd0;
                        r_zero_cnt   <= 2'd0;
                        r_elems      <= '0;
                        r_elem_count <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign letter       = r_letter;
    assign letter_valid = r_letter_valid;
    assign error        = r_error;
    assign busy         = r_busy;
    assign elem_count   = r_elem_count;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: stimulus queues expected pulses with
// their due cycle, a monitor pops and compares whenever a pulse appears.
module tb_morse_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sym_tick = 1'b0;
    logic       morse_in = 1'b0;
    logic [2:0] letter;
    logic       letter_valid;
    logic       error;
    logic       busy;
    logic [2:0] elem_count;

    typedef struct {
        bit         err;
        logic [2:0] letter;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [2:0] exp_letter = 3'b000;

    morse_decoder #(.MAX_ELEMS(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sym_tick     (sym_tick),
        .morse_in     (morse_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .error        (error),
        .busy         (busy),
        .elem_count   (elem_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bits are sent MSB first from bits[n-1]; ev_idx is the 1-based deciding tick (0 = none).
    task automatic send_seq(input logic [31:0] bits, input int n, input int ev_idx,
                            input bit ev_err, input logic [2:0] ev_letter, input int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i + 1 == ev_idx) begin
                e.err    = ev_err;
                e.letter = ev_err ? exp_letter : ev_letter;
                e.cyc    = cyc + 1;
                sb_q.push_back(e);
                if (!ev_err) exp_letter = ev_letter;
            end
            sym_tick = 1'b1;
            morse_in = bits[n-1-i];
            @(negedge clock);
            sym_tick = 1'b0;
            morse_in = 1'b0;
            repeat (gap) @(negedge clock);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && (letter_valid || error)) begin
            if (letter_valid && error) begin
                check("valid_and_error", 32'd1, 32'd0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_pulse", {31'd0, error}, 32'd2);
            end else begin
                e = sb_q.pop_front();
                check("evt_kind", {31'd0, error}, {31'd0, e.err});
                check("evt_letter", {29'd0, letter}, {29'd0, e.letter});
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_letter", {29'd0, letter}, 32'd0);
        check("rst_pulses", {30'd0, letter_valid, error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_elem_count", {29'd0, elem_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        send_seq(32'b10101000, 8, 8, 1'b0, 3'b000, 0);
        check("s_busy_after", {31'd0, busy}, 32'd0);
        send_seq(32'b1010111000, 10, 10, 1'b0, 3'b010, 0);
        send_seq(32'b101010111000, 12, 12, 1'b0, 3'b011, 0);
        send_seq(32'b101110111000, 12, 12, 1'b0, 3'b100, 0);
        send_seq(32'b11101010111000, 14, 14, 1'b0, 3'b101, 0);
        send_seq(32'b1110101110111000, 16, 16, 1'b0, 3'b110, 0);

        send_seq(32'b111011101010, 12, 0, 1'b0, 3'b000, 0);
        check("z_elem_count", {29'd0, elem_count}, 32'd4);
        send_seq(32'b00, 2, 2, 1'b0, 3'b111, 0);
        check("z_elem_clear", {29'd0, elem_count}, 32'd0);

        send_seq(32'b1100, 4, 3, 1'b1, 3'b000, 0);
        check("run2_busy", {31'd0, busy}, 32'd1);
        send_seq(32'b0, 1, 0, 1'b0, 3'b000, 0);
        check("run2_idle", {31'd0, busy}, 32'd0);

        send_seq(32'b1010101010, 10, 10, 1'b1, 3'b000, 0);
        check("ovf_elem_count", {29'd0, elem_count}, 32'd0);
        send_seq(32'b00, 2, 0, 1'b0, 3'b000, 0);
        check("ovf_idle", {31'd0, busy}, 32'd0);
        check("ovf_letter", {29'd0, letter}, 32'd7);

        send_seq(32'b111100100, 9, 4, 1'b1, 3'b000, 0);
        check("long_busy", {31'd0, busy}, 32'd1);
        send_seq(32'b0, 1, 0, 1'b0, 3'b000, 0);
        check("long_idle", {31'd0, busy}, 32'd0);

        send_seq(32'b1001000, 7, 4, 1'b1, 3'b000, 0);
        check("gap2_idle", {31'd0, busy}, 32'd0);
        send_seq(32'b1110111000, 10, 10, 1'b1, 3'b000, 0);

        send_seq(32'b1110, 4, 0, 1'b0, 3'b000, 6);
        check("slow_busy", {31'd0, busy}, 32'd1);
        check("slow_elem_count", {29'd0, elem_count}, 32'd1);
        send_seq(32'b00, 2, 2, 1'b0, 3'b001, 6);
        check("slow_idle", {31'd0, busy}, 32'd0);

        send_seq(32'b101, 3, 0, 1'b0, 3'b000, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_letter", {29'd0, letter}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_elem_count", {29'd0, elem_count}, 32'd0);
        check("mid_rst_pulses", {30'd0, letter_valid, error}, 32'd0);
        exp_letter = 3'b000;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_seq(32'b111000, 6, 6, 1'b0, 3'b001, 0);
        check("post_rst_letter", {29'd0, letter}, 32'd1);

        repeat (4) @(negedge clock);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
